// File: rtl/ps2_matrix_ctrl_pkg.sv
// Shared types and PS/2 protocol constants for the MZ-80A keyboard matrix controller.
package mz_kbd_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BRK     = 2'd1,
    EXT     = 2'd2,
    EXT_BRK = 2'd3
  } kbd_state_t;

  localparam logic [7:0] PS2_BRK       = 8'hF0;
  localparam logic [7:0] PS2_EXT       = 8'hE0;
  localparam logic [7:0] PS2_BAT       = 8'hAA;
  localparam logic [7:0] PS2_ERR       = 8'hFF;
  localparam logic [7:0] PS2_FAKESHIFT = 8'h12;
  localparam logic [7:0] PS2_F12       = 8'h07;

  typedef struct packed {
    logic       hit;
    logic [3:0] row;
    logic [2:0] col;
  } key_pos_t;

  function automatic key_pos_t key_at(input logic [3:0] row, input logic [2:0] col);
    key_pos_t p;
    p.hit = 1'b1;
    p.row = row;
    p.col = col;
    return p;
  endfunction

endpackage

// File: rtl/ps2_matrix_ctrl_if.sv
// Scan-code input and PPI row-read signals of the keyboard matrix controller.
// MZ_KBD_HOTKEY_EN adds the cpu_reset_req hotkey output.
interface ps2_matrix_ctrl_if;
  logic       dten;
  logic [7:0] kdata;
  logic [3:0] row_sel;
  logic [7:0] row_data;
  logic       key_any;
  logic       seq_err;
`ifdef MZ_KBD_HOTKEY_EN
  logic       cpu_reset_req;

  modport master (output dten, kdata, row_sel, input row_data, key_any, seq_err, cpu_reset_req);
  modport slave  (input dten, kdata, row_sel, output row_data, key_any, seq_err, cpu_reset_req);
`else
  modport master (output dten, kdata, row_sel, input row_data, key_any, seq_err);
  modport slave  (input dten, kdata, row_sel, output row_data, key_any, seq_err);
`endif
endinterface

// File: rtl/ps2_matrix_ctrl_keymap.sv
// Combinational PS/2 set-2 scan code to MZ-80A matrix position table.
module ps2_keymap
  import mz_kbd_pkg::*;
(
  input  logic     i_ext,
  input  logic [7:0] i_code,
  output key_pos_t o_pos
);

  always_comb begin
    o_pos = '0;
    case ({i_ext, i_code})
      9'h016: o_pos = key_at(4'd0, 3'd0);  9'h01E: o_pos = key_at(4'd0, 3'd1);
      9'h026: o_pos = key_at(4'd0, 3'd2);  9'h025: o_pos = key_at(4'd0, 3'd3);
      9'h02E: o_pos = key_at(4'd0, 3'd4);  9'h036: o_pos = key_at(4'd0, 3'd5);
      9'h03D: o_pos = key_at(4'd0, 3'd6);  9'h03E: o_pos = key_at(4'd0, 3'd7);
      9'h046: o_pos = key_at(4'd1, 3'd0);  9'h045: o_pos = key_at(4'd1, 3'd1);
      9'h04E: o_pos = key_at(4'd1, 3'd2);  9'h055: o_pos = key_at(4'd1, 3'd3);
      9'h066: o_pos = key_at(4'd1, 3'd4);  9'h00D: o_pos = key_at(4'd1, 3'd5);
      9'h05A: o_pos = key_at(4'd1, 3'd6);  9'h029: o_pos = key_at(4'd1, 3'd7);
      9'h015: o_pos = key_at(4'd2, 3'd0);  9'h01D: o_pos = key_at(4'd2, 3'd1);
      9'h024: o_pos = key_at(4'd2, 3'd2);  9'h02D: o_pos = key_at(4'd2, 3'd3);
      9'h02C: o_pos = key_at(4'd2, 3'd4);  9'h035: o_pos = key_at(4'd2, 3'd5);
      9'h03C: o_pos = key_at(4'd2, 3'd6);  9'h043: o_pos = key_at(4'd2, 3'd7);
      9'h044: o_pos = key_at(4'd3, 3'd0);  9'h04D: o_pos = key_at(4'd3, 3'd1);
      9'h054: o_pos = key_at(4'd3, 3'd2);  9'h05B: o_pos = key_at(4'd3, 3'd3);
      9'h04C: o_pos = key_at(4'd3, 3'd4);  9'h052: o_pos = key_at(4'd3, 3'd5);
      9'h05D: o_pos = key_at(4'd3, 3'd6);  9'h00E: o_pos = key_at(4'd3, 3'd7);
      9'h01C: o_pos = key_at(4'd4, 3'd0);  9'h01B: o_pos = key_at(4'd4, 3'd1);
      9'h023: o_pos = key_at(4'd4, 3'd2);  9'h02B: o_pos = key_at(4'd4, 3'd3);
      9'h034: o_pos = key_at(4'd4, 3'd4);  9'h033: o_pos = key_at(4'd4, 3'd5);
      9'h03B: o_pos = key_at(4'd4, 3'd6);  9'h042: o_pos = key_at(4'd4, 3'd7);
      9'h04B: o_pos = key_at(4'd5, 3'd0);  9'h01A: o_pos = key_at(4'd5, 3'd1);
      9'h022: o_pos = key_at(4'd5, 3'd2);  9'h021: o_pos = key_at(4'd5, 3'd3);
      9'h02A: o_pos = key_at(4'd5, 3'd4);  9'h031: o_pos = key_at(4'd5, 3'd5);
      9'h03A: o_pos = key_at(4'd5, 3'd6);  9'h041: o_pos = key_at(4'd5, 3'd7);
      9'h049: o_pos = key_at(4'd6, 3'd0);  9'h04A: o_pos = key_at(4'd6, 3'd1);
      9'h032: o_pos = key_at(4'd6, 3'd2);  9'h012: o_pos = key_at(4'd6, 3'd3);
      9'h059: o_pos = key_at(4'd6, 3'd4);  9'h014: o_pos = key_at(4'd6, 3'd5);
      9'h076: o_pos = key_at(4'd6, 3'd6);  9'h058: o_pos = key_at(4'd6, 3'd7);
      // Cursor and editing keys only exist behind the E0 prefix
      9'h16B: o_pos = key_at(4'd7, 3'd0);  9'h174: o_pos = key_at(4'd7, 3'd1);
      9'h172: o_pos = key_at(4'd7, 3'd2);  9'h16C: o_pos = key_at(4'd7, 3'd3);
      9'h175: o_pos = key_at(4'd7, 3'd4);  9'h171: o_pos = key_at(4'd7, 3'd5);
      9'h170: o_pos = key_at(4'd7, 3'd6);  9'h005: o_pos = key_at(4'd7, 3'd7);
      9'h006: o_pos = key_at(4'd8, 3'd0);  9'h004: o_pos = key_at(4'd8, 3'd1);
      9'h00C: o_pos = key_at(4'd8, 3'd2);  9'h003: o_pos = key_at(4'd8, 3'd3);
      9'h00B: o_pos = key_at(4'd8, 3'd4);  9'h083: o_pos = key_at(4'd8, 3'd5);
      9'h00A: o_pos = key_at(4'd8, 3'd6);  9'h001: o_pos = key_at(4'd8, 3'd7);
      9'h009: o_pos = key_at(4'd9, 3'd0);  9'h078: o_pos = key_at(4'd9, 3'd1);
      9'h111: o_pos = key_at(4'd9, 3'd2);  9'h011: o_pos = key_at(4'd9, 3'd3);
      9'h114: o_pos = key_at(4'd9, 3'd4);  9'h15A: o_pos = key_at(4'd9, 3'd5);
      9'h07C: o_pos = key_at(4'd9, 3'd6);  9'h079: o_pos = key_at(4'd9, 3'd7);
      default: o_pos = '0;
    endcase
  end

endmodule

// File: rtl/ps2_matrix_ctrl.sv
// PS/2 byte stream to MZ-80A active-low key matrix, read by the 8255 row strobe.
// MZ_KBD_HOTKEY_EN: F12 make pulses cpu_reset_req instead of reaching the matrix.
//
// state   | meaning
// IDLE    | no prefix pending; next byte is a make or a control byte
// BRK     | F0 seen; next byte is a break
// EXT     | E0 seen; next byte is an extended make
// EXT_BRK | E0 F0 seen; next byte is an extended break
module ps2_matrix_ctrl
  import mz_kbd_pkg::*;
#(
  parameter int ROWS        = 10,
  parameter int TIMEOUT_CYC = 20000
) (
  input logic              clk,
  input logic              reset,
  ps2_matrix_ctrl_if.slave bus
);

  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYC - 1);

  kbd_state_t             r_state, w_state_nxt;
  logic [CNT_W-1:0]       r_to_cnt;
  logic [ROWS-1:0][7:0]   r_matrix;
  logic [7:0]             r_row_data;
  logic                   r_key_any;
  logic                   r_seq_err;
  logic [7:0]             w_row_rd;
  logic                   w_ext, w_timeout;
  logic                   w_do_make, w_do_break, w_do_clear, w_seq_err;
  key_pos_t               w_pos;
`ifdef MZ_KBD_HOTKEY_EN
  logic                   w_hotkey;
  logic                   r_cpu_reset_req;
`endif

  assign w_ext     = (r_state == EXT) || (r_state == EXT_BRK);
  assign w_timeout = (r_state != IDLE) && !bus.dten && (r_to_cnt == TO_LAST);

  ps2_keymap u_keymap (
    .i_ext  (w_ext),
    .i_code (bus.kdata),
    .o_pos  (w_pos)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_do_make   = 1'b0;
    w_do_break  = 1'b0;
    w_do_clear  = 1'b0;
    w_seq_err   = 1'b0;
`ifdef MZ_KBD_HOTKEY_EN
    w_hotkey    = 1'b0;
`endif
    if (bus.dten) begin
      case (r_state)
        IDLE: begin
          case (bus.kdata)
            PS2_BRK: w_state_nxt = BRK;
            PS2_EXT: w_state_nxt = EXT;
            PS2_BAT: w_do_clear  = 1'b1;
            PS2_ERR: begin
              w_do_clear = 1'b1;
              w_seq_err  = 1'b1;
            end
            default: begin
`ifdef MZ_KBD_HOTKEY_EN
              if (bus.kdata == PS2_F12) w_hotkey  = 1'b1;
              else                      w_do_make = 1'b1;
`else
              w_do_make = 1'b1;
`endif
            end
          endcase
        end
        EXT: begin
          case (bus.kdata)
            PS2_BRK:       w_state_nxt = EXT_BRK;
            PS2_EXT:       w_state_nxt = EXT;
            PS2_FAKESHIFT: w_state_nxt = IDLE;
            default: begin
              w_do_make   = 1'b1;
              w_state_nxt = IDLE;
            end
          endcase
        end
        BRK, EXT_BRK: begin
          w_do_break  = 1'b1;
          w_state_nxt = IDLE;
        end
        default: w_state_nxt = IDLE;
      endcase
    end else if (w_timeout) begin
      w_state_nxt = IDLE;
      w_seq_err   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_to_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (bus.dten || (w_state_nxt == IDLE)) r_to_cnt <= '0;
      else                                   r_to_cnt <= r_to_cnt + CNT_W'(1);
    end
  end

  // Rows beyond ROWS are not stored and always read back as released
  always_comb begin
    w_row_rd = 8'hFF;
    for (int r = 0; r < ROWS; r++) begin
      if (bus.row_sel == 4'(r)) w_row_rd = r_matrix[r];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_matrix   <= '1;
      r_row_data <= 8'hFF;
      r_key_any  <= 1'b0;
      r_seq_err  <= 1'b0;
    end else begin
      if (w_do_clear) begin
        r_matrix <= '1;
      end else if ((w_do_make || w_do_break) && w_pos.hit) begin
        for (int r = 0; r < ROWS; r++) begin
          if (w_pos.row == 4'(r)) r_matrix[r][w_pos.col] <= w_do_break;
        end
      end
      r_row_data <= w_row_rd;
      r_key_any  <= ~&r_matrix;
      r_seq_err  <= w_seq_err;
    end
  end

  assign bus.row_data = r_row_data;
  assign bus.key_any  = r_key_any;
  assign bus.seq_err  = r_seq_err;

`ifdef MZ_KBD_HOTKEY_EN
  always_ff @(posedge clk) begin
    if (reset) r_cpu_reset_req <= 1'b0;
    else       r_cpu_reset_req <= w_hotkey;
  end

  assign bus.cpu_reset_req = r_cpu_reset_req;
`endif

endmodule

// File: tb/tb_ps2_matrix_ctrl.sv
// Bench for ps2_matrix_ctrl: directed scan-code sequences checked against a key-table model.
// Honours MZ_KBD_HOTKEY_EN when the design is built with it.
module tb_ps2_matrix_ctrl;

  localparam int TB_ROWS = 10;
  localparam int TB_TO   = 64;

  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;
  int   n_err_pulse;
  int   n_hot_pulse;

  ps2_matrix_ctrl_if bus ();

  ps2_matrix_ctrl #(
    .ROWS        (TB_ROWS),
    .TIMEOUT_CYC (TB_TO)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h expected %02h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: key table as {ext,code} -> row*8+col, matrix as plain bytes, prefix as flags
  int         keytab [int];
  logic [7:0] m_mat [0:15];
  bit         m_pref, m_brk, m_ext, m_valid;
  int         m_wait;
  logic [7:0] e_row;
  bit         e_any, e_err, e_hot;

  initial begin
    keytab[9'h01C] = 4*8 + 0;
    keytab[9'h01B] = 4*8 + 1;
    keytab[9'h032] = 6*8 + 2;
    keytab[9'h012] = 6*8 + 3;
    keytab[9'h016] = 0*8 + 0;
    keytab[9'h078] = 9*8 + 1;
    keytab[9'h175] = 7*8 + 4;
    keytab[9'h16B] = 7*8 + 0;
    for (int r = 0; r < 16; r++) m_mat[r] = 8'hFF;
    m_valid = 0;
  end

  function automatic void m_key(input bit ext, input logic [7:0] code, input bit brk);
    int k, row, col;
    k = int'({ext, code});
    if (keytab.exists(k)) begin
      row = keytab[k] / 8;
      col = keytab[k] % 8;
      if (row < TB_ROWS) m_mat[row][col] = brk;
    end
  endfunction

  function automatic void m_byte(input logic [7:0] b);
    m_wait = 0;
    if (!m_pref) begin
      if (b == 8'hF0) begin m_pref = 1; m_brk = 1; m_ext = 0; end
      else if (b == 8'hE0) begin m_pref = 1; m_brk = 0; m_ext = 1; end
      else if (b == 8'hAA || b == 8'hFF) begin
        for (int r = 0; r < 16; r++) m_mat[r] = 8'hFF;
        e_err = (b == 8'hFF);
      end
`ifdef MZ_KBD_HOTKEY_EN
      else if (b == 8'h07) e_hot = 1;
`endif
      else m_key(0, b, 0);
    end else if (m_ext && !m_brk) begin
      if (b == 8'hF0) m_brk = 1;
      else if (b == 8'hE0) m_pref = 1;
      else if (b == 8'h12) m_pref = 0;
      else begin m_key(1, b, 0); m_pref = 0; end
    end else begin
      m_key(m_ext, b, 1);
      m_pref = 0;
    end
  endfunction

  always @(posedge clk) begin
    e_row = m_mat[bus.row_sel];
    e_any = 0;
    for (int r = 0; r < 16; r++) if (m_mat[r] != 8'hFF) e_any = 1;
    e_err = 0;
    e_hot = 0;
    if (reset) begin
      for (int r = 0; r < 16; r++) m_mat[r] = 8'hFF;
      m_pref = 0; m_brk = 0; m_ext = 0; m_wait = 0;
      e_row = 8'hFF; e_any = 0;
    end else if (bus.dten) begin
      m_byte(bus.kdata);
    end else if (m_pref) begin
      if (m_wait == TB_TO - 1) begin
        m_pref = 0; m_wait = 0; e_err = 1;
      end else begin
        m_wait++;
      end
    end
    m_valid = 1;
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("cyc_row_data", bus.row_data, e_row);
      chk("cyc_key_any", 8'(bus.key_any), 8'(e_any));
      chk("cyc_seq_err", 8'(bus.seq_err), 8'(e_err));
`ifdef MZ_KBD_HOTKEY_EN
      chk("cyc_cpu_reset_req", 8'(bus.cpu_reset_req), 8'(e_hot));
      if (bus.cpu_reset_req) n_hot_pulse++;
`endif
      if (bus.seq_err) n_err_pulse++;
    end
  end

  task automatic send(input logic [7:0] b);
    bus.dten  = 1'b1;
    bus.kdata = b;
    @(negedge clk);
    bus.dten  = 1'b0;
  endtask

  task automatic read_row(input int r, input logic [7:0] exp, input string nm);
    bus.row_sel = 4'(r);
    @(negedge clk);
    chk(nm, bus.row_data, exp);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    n_tests = 0; n_fail = 0; n_err_pulse = 0; n_hot_pulse = 0;
    reset = 1'b1;
    bus.dten = 1'b0; bus.kdata = 8'h00; bus.row_sel = 4'd0;
    idle(3);
    chk("rst_row_data", bus.row_data, 8'hFF);
    chk("rst_key_any", 8'(bus.key_any), 8'h00);
    chk("rst_seq_err", 8'(bus.seq_err), 8'h00);
    reset = 1'b0;
    idle(1);

    for (int r = 0; r < 16; r++) read_row(r, 8'hFF, "sweep_idle");
    chk("sweep_key_any", 8'(bus.key_any), 8'h00);

    send(8'h1C);
    read_row(4, 8'hFE, "make_a_row4");
    chk("make_a_key_any", 8'(bus.key_any), 8'h01);
    send(8'hF0); send(8'h1C);
    read_row(4, 8'hFF, "break_a_row4");
    chk("break_a_key_any", 8'(bus.key_any), 8'h00);

    send(8'h1C); send(8'h32); send(8'hF0); send(8'h1C);
    read_row(4, 8'hFF, "two_keys_row4");
    read_row(6, 8'hFB, "two_keys_row6");
    repeat (5) send(8'h1C);
    read_row(4, 8'hFE, "typematic_row4");
    read_row(6, 8'hFB, "typematic_row6");
    read_row(0, 8'hFF, "typematic_row0");
    send(8'h16); send(8'h78);
    read_row(0, 8'hFE, "row0_key1");
    read_row(9, 8'hFD, "row9_f11");
    for (int r = 10; r < 16; r++) read_row(r, 8'hFF, "row_beyond_rows");
    send(8'hF0); send(8'h16); send(8'hF0); send(8'h78);
    send(8'hF0); send(8'h1B);
    read_row(4, 8'hFE, "stray_break_row4");

    send(8'hE0); send(8'h75);
    read_row(7, 8'hEF, "ext_up_row7");
    read_row(4, 8'hFE, "ext_up_row4");
    send(8'h75);
    read_row(4, 8'hFE, "plain75_row4");
    read_row(7, 8'hEF, "plain75_row7");
    send(8'hE0); send(8'hF0); send(8'h75);
    read_row(7, 8'hFF, "ext_brk_row7");
    send(8'hE0); send(8'h12);
    read_row(6, 8'hFB, "fakeshift_row6");
    send(8'hE0); send(8'hE0); send(8'h6B);
    read_row(7, 8'hFE, "double_e0_left");
    bus.row_sel = 4'd7;
    send(8'hE0); send(8'hF0); send(8'h6B);
    chk("same_row_pre", bus.row_data, 8'hFE);
    idle(1);
    chk("same_row_post", bus.row_data, 8'hFF);

    send(8'hF0); send(8'h1C);
    read_row(4, 8'hFF, "pre_timeout_row4");
    n_err_pulse = 0;
    send(8'hF0);
    idle(TB_TO - 3);
    send(8'h1C);
    read_row(4, 8'hFF, "late_break_row4");
    chk("late_break_no_err", 8'(n_err_pulse), 8'h00);
    n_err_pulse = 0;
    send(8'hF0);
    idle(TB_TO + 5);
    chk("timeout_err_pulses", 8'(n_err_pulse), 8'h01);
    send(8'h1C);
    read_row(4, 8'hFE, "post_timeout_make");

    send(8'hE0); send(8'h75); send(8'h78);
    send(8'hAA);
    read_row(4, 8'hFF, "bat_row4");
    read_row(6, 8'hFF, "bat_row6");
    read_row(7, 8'hFF, "bat_row7");
    read_row(9, 8'hFF, "bat_row9");
    chk("bat_key_any", 8'(bus.key_any), 8'h00);
    send(8'h1C);
    n_err_pulse = 0;
    send(8'hFF);
    read_row(4, 8'hFF, "err_row4");
    chk("err_pulses", 8'(n_err_pulse), 8'h01);

    send(8'hF0);
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    send(8'h1C);
    read_row(4, 8'hFE, "reset_mid_make");

    n_hot_pulse = 0;
    send(8'h07);
    idle(3);
    read_row(4, 8'hFE, "f12_row4");
    chk("f12_key_any", 8'(bus.key_any), 8'h01);
`ifdef MZ_KBD_HOTKEY_EN
    chk("f12_hot_pulses", 8'(n_hot_pulse), 8'h01);
`endif
    idle(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
